// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle CPU front end: opcode and function
// codes, fetch fault codes, the NOP word, the IF memory state type and the
// fetch fault classification helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Primary opcodes (instruction word bits 31:26)
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instruction word bits 5:0)
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // Fetch response fault codes
    localparam logic [1:0] FLT_OK       = 2'd0;
    localparam logic [1:0] FLT_MISALIGN = 2'd1;
    localparam logic [1:0] FLT_RANGE    = 2'd2;

    // All-zero word decodes as a harmless NOP
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } imem_state_e;

    // Classify a byte-address fetch. Misalignment is reported ahead of range.
    function automatic logic [1:0] fault_code(input logic [31:0] pc,
                                              input logic [31:0] depth);
        logic [1:0] code;
        code = FLT_OK;
        if (pc[1:0] != 2'b00) begin
            code = FLT_MISALIGN;
        end else if ({2'b00, pc[31:2]} >= depth) begin
            code = FLT_RANGE;
        end else begin
            code = FLT_OK;
        end
        return code;
    endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem_if
// Bundles the program-load port, the fetch request handshake and the fetch
// response handshake of the instruction memory.
//   master : load/request driver and response consumer (CPU / loader side)
//   slave  : the instruction memory
// Parameter AW is the word-index width of ld_addr.
// ---------------------------------------------------------------------------
interface instr_fetch_mem_if #(
    parameter int AW = 6
);
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_busy;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   pc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [5:0]    ins_Opcode;
    logic [4:0]    ins_rs;
    logic [4:0]    ins_rt;
    logic [4:0]    ins_rd;
    logic [5:0]    ins_func;
    logic [25:0]   ins_imm;
    logic [1:0]    rsp_fault;

    modport master (
        output ld_en, ld_addr, ld_data, req_valid, pc, rsp_ready,
        input  ld_busy, req_ready, rsp_valid,
        input  ins_Opcode, ins_rs, ins_rt, ins_rd, ins_func, ins_imm, rsp_fault
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, req_valid, pc, rsp_ready,
        output ld_busy, req_ready, rsp_valid,
        output ins_Opcode, ins_rs, ins_rt, ins_rd, ins_func, ins_imm, rsp_fault
    );
endinterface

// File: rtl/imem_ram.sv
// ---------------------------------------------------------------------------
// imem_ram
// Single-port DEPTH x 32 RAM, synchronous write and synchronous read, written
// so that it maps onto block RAM. A write cycle does not update the read
// register, so the last read word stays put until the next read.
// Ports:
//   clk   in  clock
//   we    in  write enable (wins over re)
//   re    in  read enable
//   addr  in  word index
//   wdata in  write data
//   rdata out registered read data
// ---------------------------------------------------------------------------
module imem_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Storage array write and registered read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// instr_fetch_mem
// Handshaked instruction memory for the IF stage. After reset a clear sweep
// writes NOP into every word (one per cycle), then the memory accepts program
// loads and fetches. Each accepted fetch yields one registered response with
// the instruction pre-split into fields and a fault code.
// Ports:
//   IF_clk  in  clock
//   rst     in  synchronous active-high reset
//   bus     slave modport of instr_fetch_mem_if (load, request, response)
// ---------------------------------------------------------------------------
module instr_fetch_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              IF_clk,
    input  logic              rst,
    instr_fetch_mem_if.slave  bus
);
    imem_state_e   state_r, state_nxt_s;
    logic [AW-1:0] clr_cnt_r, clr_cnt_nxt_s;
    logic          rsp_valid_r;
    logic [1:0]    rsp_fault_r;
    logic          fetch_ok_r;
    logic          req_ready_s;
    logic          hs_s;
    logic [1:0]    req_fault_s;
    logic          ram_we_s;
    logic          ram_re_s;
    logic [AW-1:0] ram_addr_s;
    logic [31:0]   ram_wdata_s;
    logic [31:0]   ram_rdata_s;
    logic [31:0]   word_s;

    // State and sweep counter registers
    always_ff @(posedge IF_clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {AW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Next state: sweep every index once, then stay in RUN until reset
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                clr_cnt_nxt_s = clr_cnt_r + {{(AW-1){1'b0}}, 1'b1};
                if (clr_cnt_r == AW'(DEPTH - 1)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_cnt_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // A load owns the single RAM port, so it blocks fetch acceptance
    assign req_ready_s = (state_r == ST_RUN) && !bus.ld_en &&
                         (!rsp_valid_r || bus.rsp_ready);
    assign hs_s        = bus.req_valid && req_ready_s;
    assign req_fault_s = fault_code(bus.pc, 32'(DEPTH));

    // RAM port arbitration: sweep, then load, then fetch read
    always_comb begin
        ram_we_s    = 1'b0;
        ram_re_s    = 1'b0;
        ram_addr_s  = bus.pc[AW+1:2];
        ram_wdata_s = NOP_WORD;
        if (rst) begin
            ram_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = clr_cnt_r;
            ram_wdata_s = NOP_WORD;
        end else if (bus.ld_en) begin
            ram_we_s    = 1'b1;
            ram_addr_s  = bus.ld_addr;
            ram_wdata_s = bus.ld_data;
        end else begin
            // Faulted fetches leave the read register alone; the word is
            // masked to NOP anyway.
            ram_re_s = hs_s && (req_fault_s == FLT_OK);
        end
    end

    // Response registers: load on handshake, drop on consume, hold otherwise
    always_ff @(posedge IF_clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_fault_r <= FLT_OK;
            fetch_ok_r  <= 1'b0;
        end else if (hs_s) begin
            rsp_valid_r <= 1'b1;
            rsp_fault_r <= req_fault_s;
            fetch_ok_r  <= (req_fault_s == FLT_OK);
        end else if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (IF_clk),
        .we    (ram_we_s),
        .re    (ram_re_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // The RAM read register is the response data; it only moves on a good
    // fetch, which gives the hold-under-backpressure behaviour for free.
    assign word_s = fetch_ok_r ? ram_rdata_s : NOP_WORD;

    assign bus.ld_busy    = (state_r == ST_CLEAR);
    assign bus.req_ready  = req_ready_s;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_fault  = rsp_fault_r;
    assign bus.ins_Opcode = word_s[31:26];
    assign bus.ins_rs     = word_s[25:21];
    assign bus.ins_rt     = word_s[20:16];
    assign bus.ins_rd     = word_s[15:11];
    assign bus.ins_func   = word_s[5:0];
    assign bus.ins_imm    = word_s[25:0];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_mem
// Directed bench for instr_fetch_mem (DEPTH = 64). A transaction-level model
// (word array, sweep countdown, single response slot) predicts every output
// and is compared on each falling edge; directed steps add literal checks.
// Inputs change 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_mem;
    import cpu_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_busy;

    instr_fetch_mem_if #(.AW(AW)) bus();

    instr_fetch_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .IF_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model state
    logic [31:0] m_mem [DEPTH];
    int          m_sweep;
    bit          m_valid;
    logic [31:0] m_word;
    logic [1:0]  m_fault;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (m_sweep == 0) && !bus.ld_en && (!m_valid || bus.rsp_ready);
    endfunction

    // Model update on each rising edge
    initial begin
        m_sweep = DEPTH;
        m_valid = 1'b0;
        m_word  = 32'h0;
        m_fault = 2'd0;
        forever begin
            bit rdy;
            @(posedge clk);
            rdy = model_ready();
            if (rst) begin
                m_sweep = DEPTH;
                m_valid = 1'b0;
                m_word  = 32'h0;
                m_fault = 2'd0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
            end else begin
                if (m_sweep > 0) m_sweep--;
                else if (bus.ld_en) m_mem[bus.ld_addr] = bus.ld_data;
                if (bus.req_valid && rdy) begin
                    if (bus.pc % 4 != 0) begin
                        m_fault = 2'd1; m_word = 32'h0;
                    end else if (bus.pc / 4 >= DEPTH) begin
                        m_fault = 2'd2; m_word = 32'h0;
                    end else begin
                        m_fault = 2'd0; m_word = m_mem[bus.pc / 4];
                    end
                    m_valid = 1'b1;
                end else if (bus.rsp_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Compare DUT against model on every falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("m_ld_busy",   bus.ld_busy,    32'(m_sweep != 0));
                check("m_req_ready", bus.req_ready,  32'(model_ready()));
                check("m_rsp_valid", bus.rsp_valid,  32'(m_valid));
                check("m_fault",     bus.rsp_fault,  32'(m_fault));
                check("m_opcode",    bus.ins_Opcode, 32'(m_word[31:26]));
                check("m_rs",        bus.ins_rs,     32'(m_word[25:21]));
                check("m_rt",        bus.ins_rt,     32'(m_word[20:16]));
                check("m_rd",        bus.ins_rd,     32'(m_word[15:11]));
                check("m_func",      bus.ins_func,   32'(m_word[5:0]));
                check("m_imm",       bus.ins_imm,    32'(m_word[25:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        step();
        bus.ld_en   = 1'b0;
    endtask

    // One fetch with rsp_ready high; fields stay readable after return
    task automatic fetch(input logic [31:0] addr);
        bus.req_valid = 1'b1;
        bus.pc        = addr;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("fetch_ready", bus.req_ready, 32'd1);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("fetch_valid", bus.rsp_valid, 32'd1);
        step();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.ld_busy) n++;
            else break;
        end
        step();
    endtask

    initial begin
        rst           = 1'b1;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = 32'h0;
        bus.req_valid = 1'b0;
        bus.pc        = 32'h0;
        bus.rsp_ready = 1'b0;

        // Reset state
        @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid",  bus.rsp_valid,  32'd0);
        check("rst_busy",   bus.ld_busy,    32'd1);
        check("rst_ready",  bus.req_ready,  32'd0);
        check("rst_opcode", bus.ins_Opcode, 32'd0);
        check("rst_fault",  bus.rsp_fault,  32'd0);
        step();
        rst = 1'b0;

        // Sweep length
        count_busy(n_busy);
        check("sweep_len", n_busy, 32'd64);
        check("sweep_ready", bus.req_ready, 32'd1);

        // Cleared word
        fetch(32'h10);
        check("clr_opcode", bus.ins_Opcode, 32'd0);
        check("clr_imm",    bus.ins_imm,    32'd0);
        check("clr_fault",  bus.rsp_fault,  32'd0);

        // Load then fetch next cycle
        load(6'd3, 32'h3464_27C3);
        fetch(32'hC);
        check("ld_opcode", bus.ins_Opcode, 32'h0D);
        check("ld_rs",     bus.ins_rs,     32'd3);
        check("ld_rt",     bus.ins_rt,     32'd4);
        check("ld_imm",    bus.ins_imm,    32'h06427C3);
        check("ld_fault",  bus.rsp_fault,  32'd0);

        // Faults, including addresses that alias the loaded word
        fetch(32'h6);
        check("mis_fault",  bus.rsp_fault,  32'd1);
        check("mis_opcode", bus.ins_Opcode, 32'd0);
        fetch(32'h100);
        check("rng_fault",  bus.rsp_fault,  32'd2);
        fetch(32'h102);
        check("both_fault", bus.rsp_fault,  32'd1);
        fetch(32'h10C);
        check("alias_rng_fault", bus.rsp_fault, 32'd2);
        check("alias_rng_imm",   bus.ins_imm,   32'd0);
        fetch(32'hE);
        check("alias_mis_fault", bus.rsp_fault, 32'd1);
        check("alias_mis_imm",   bus.ins_imm,   32'd0);

        // Last word in range
        load(6'd63, 32'hAC22_0008);
        fetch(32'hFC);
        check("last_fault",  bus.rsp_fault,  32'd0);
        check("last_opcode", bus.ins_Opcode, 32'h2B);

        // Backpressure with a memory write under the held response
        load(6'd5, 32'h8C01_0004);
        load(6'd6, 32'h0022_1820);
        bus.req_valid = 1'b1;
        bus.pc        = 32'h14;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_first_ready", bus.req_ready, 32'd1);
        step();
        bus.pc = 32'h18;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready",  bus.req_ready,  32'd0);
            check("bp_valid",  bus.rsp_valid,  32'd1);
            check("bp_opcode", bus.ins_Opcode, 32'h23);
            check("bp_rt",     bus.ins_rt,     32'd1);
            check("bp_imm",    bus.ins_imm,    32'h0010004);
            step();
            if (i == 0) begin
                bus.ld_en   = 1'b1;
                bus.ld_addr = 6'd5;
                bus.ld_data = 32'hFFFF_FFFF;
            end else begin
                bus.ld_en   = 1'b0;
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", bus.req_ready, 32'd1);
        step();
        bus.pc = 32'h14;
        @(negedge clk);
        check("b2b1_valid", bus.rsp_valid, 32'd1);
        check("b2b1_func",  bus.ins_func,  32'h20);
        check("b2b1_rd",    bus.ins_rd,    32'd3);
        check("b2b1_rs",    bus.ins_rs,    32'd1);
        check("b2b1_rt",    bus.ins_rt,    32'd2);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b2_valid",  bus.rsp_valid,  32'd1);
        check("b2b2_opcode", bus.ins_Opcode, 32'h3F);
        check("b2b2_imm",    bus.ins_imm,    32'h3FF_FFFF);
        step();

        // Same-cycle write and fetch
        bus.ld_en     = 1'b1;
        bus.ld_addr   = 6'd7;
        bus.ld_data   = 32'h0800_0010;
        bus.req_valid = 1'b1;
        bus.pc        = 32'h1C;
        @(negedge clk);
        check("coll_ready", bus.req_ready, 32'd0);
        step();
        bus.ld_en = 1'b0;
        @(negedge clk);
        check("coll_ready_next", bus.req_ready, 32'd1);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("coll_valid",  bus.rsp_valid,  32'd1);
        check("coll_opcode", bus.ins_Opcode, 32'h02);
        check("coll_imm",    bus.ins_imm,    32'h10);
        step();

        // Reset with a pending response
        bus.req_valid = 1'b1;
        bus.pc        = 32'hC;
        bus.rsp_ready = 1'b0;
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pend_valid",  bus.rsp_valid,  32'd1);
        check("pend_opcode", bus.ins_Opcode, 32'h0D);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", bus.rsp_valid, 32'd0);
        check("mrst_busy",  bus.ld_busy,   32'd1);
        count_busy(n_busy);
        check("mrst_sweep_len", n_busy, 32'd64);
        fetch(32'hC);
        check("mrst_opcode", bus.ins_Opcode, 32'd0);
        check("mrst_imm",    bus.ins_imm,    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
